// File: rtl/preload_pkg.sv
// Shared constants, FSM state encoding and helper functions for the preload FIFO controller.
package preload_pkg;

    localparam int unsigned SIZE_W      = 12;
    localparam int unsigned ROW_W       = 16;
    localparam int unsigned STALL_W     = 32;
    localparam int unsigned CH_PER_WORD = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Number of bits needed to represent value (0 -> 0).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic logic [SIZE_W-1:0] words_per_row(input logic [SIZE_W-1:0] size);
        return SIZE_W'(size / SIZE_W'(CH_PER_WORD)) + SIZE_W'(1);
    endfunction

endpackage

// File: rtl/preload_fifo_ctrl_if.sv
// AXIS input and MAC-side row handshakes of the preload FIFO controller.
interface preload_fifo_ctrl_if;

    logic s_axis_tvalid;
    logic s_axis_tlast;
    logic s_axis_tready;
    logic mac_valid;
    logic mac_ready;

    modport slave (
        input  s_axis_tvalid,
        input  s_axis_tlast,
        input  mac_ready,
        output s_axis_tready,
        output mac_valid
    );

    modport master (
        output s_axis_tvalid,
        output s_axis_tlast,
        output mac_ready,
        input  s_axis_tready,
        input  mac_valid
    );

endinterface

// File: rtl/preload_row_counter.sv
// Word-within-row counter plus rows written/read tallies for the preload FIFO.
module preload_row_counter
    import preload_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr,
    input  logic              rd,
    input  logic [SIZE_W-1:0] wpr,
    output logic              row_done_c,
    output logic              row_avail_c,
    output logic [ROW_W-1:0]  rows_written,
    output logic [ROW_W-1:0]  rows_read
);

    logic [SIZE_W-1:0] word_cnt;

    assign row_done_c  = wr && (word_cnt == SIZE_W'(wpr - SIZE_W'(1)));
    // A row is only offered once every word of it is in the FIFO.
    assign row_avail_c = rows_written > rows_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt     <= '0;
            rows_written <= '0;
            rows_read    <= '0;
        end else if (clear) begin
            word_cnt     <= '0;
            rows_written <= '0;
            rows_read    <= '0;
        end else begin
            if (wr) begin
                if (row_done_c) begin
                    word_cnt     <= '0;
                    rows_written <= rows_written + ROW_W'(1);
                end else begin
                    word_cnt <= word_cnt + SIZE_W'(1);
                end
            end
            if (rd) begin
                rows_read <= rows_read + ROW_W'(1);
            end
        end
    end

endmodule

// File: rtl/preload_fifo_ctrl.sv
// Preload FIFO controller: loads AXIS words into the row FIFO and hands complete rows to the MAC.
// Optional input-stall counter enabled by defining PRELOAD_CTRL_PERF_EN.
module preload_fifo_ctrl
    import preload_pkg::*;
#(
    parameter int unsigned AXIS_PRELOAD_FIFO_DEPTH = 4,
    parameter int unsigned CNT_W                   = clogb2(AXIS_PRELOAD_FIFO_DEPTH - 1) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SIZE_W-1:0]  input_channel_size,
    input  logic [ROW_W-1:0]   row_count,
    preload_fifo_ctrl_if.slave ctrl_bus,
    input  logic [CNT_W-1:0]   fifo_cnt,
    input  logic               fifo_full,
    output logic               load_axis_preload,
    output logic               fifo_read,
    output logic               axis_clear,
    output logic               busy,
    output logic               done,
    output logic               err_tlast,
    output logic [STALL_W-1:0] stall_cycles
);

    state_t            state;
    logic [SIZE_W-1:0] wpr;
    logic [ROW_W-1:0]  rows_total;
    logic [ROW_W-1:0]  rows_written;
    logic [ROW_W-1:0]  rows_read;
    logic              start_ok_c;
    logic              row_done_c;
    logic              row_avail_c;
    logic              mac_valid_c;
    logic              ready_c;
    logic              accept_c;
    logic              final_word_c;
    logic              drain_done_c;
    logic              unused_ok;

    // Occupancy includes partially written rows, so it cannot drive mac_valid.
    assign unused_ok = ^fifo_cnt;

    assign start_ok_c   = start && (state == ST_IDLE);
    assign mac_valid_c  = ((state == ST_LOAD) || (state == ST_DRAIN)) && row_avail_c;
    assign fifo_read    = mac_valid_c && ctrl_bus.mac_ready;
    assign ready_c      = (state == ST_LOAD) && (rows_written < rows_total)
                          && (!fifo_full || fifo_read);
    assign accept_c     = ctrl_bus.s_axis_tvalid && ready_c;
    assign final_word_c = row_done_c && (ROW_W'(rows_written + ROW_W'(1)) == rows_total);
    assign drain_done_c = ROW_W'(rows_read + ROW_W'(fifo_read)) == rows_total;

    assign load_axis_preload      = accept_c;
    assign ctrl_bus.s_axis_tready = ready_c;
    assign ctrl_bus.mac_valid     = mac_valid_c;

    preload_row_counter u_row_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (start_ok_c),
        .wr           (accept_c),
        .rd           (fifo_read),
        .wpr          (wpr),
        .row_done_c   (row_done_c),
        .row_avail_c  (row_avail_c),
        .rows_written (rows_written),
        .rows_read    (rows_read)
    );

    // Job sequencing with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wpr        <= '0;
            rows_total <= '0;
            axis_clear <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_tlast  <= 1'b0;
        end else begin
            if (start_ok_c) begin
                err_tlast <= 1'b0;
            end else if (accept_c && (ctrl_bus.s_axis_tlast != final_word_c)) begin
                err_tlast <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_ok_c) begin
                        state      <= ST_CLEAR;
                        wpr        <= words_per_row(input_channel_size);
                        rows_total <= row_count;
                        axis_clear <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    axis_clear <= 1'b0;
                    if (rows_total == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (final_word_c) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done_c) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    axis_clear <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

`ifdef PRELOAD_CTRL_PERF_EN
    // Cycles the source offered a word that the FIFO could not take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (start_ok_c) begin
            stall_cycles <= '0;
        end else if ((state == ST_LOAD) && ctrl_bus.s_axis_tvalid && !ready_c
                     && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STALL_W'(1);
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_preload_fifo_ctrl.sv
// Self-checking bench for preload_fifo_ctrl: directed job table, corner sequences, random jobs.
module tb_preload_fifo_ctrl;
    import preload_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = clogb2(DEPTH - 1) + 1;
`ifdef PRELOAD_CTRL_PERF_EN
    localparam int STALL_EXP = 10;
`else
    localparam int STALL_EXP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [11:0]   size = '0;
    logic [15:0]   rows_in = '0;
    logic [CW-1:0] fifo_cnt = '0;
    logic          fifo_full = 1'b0;
    logic          load_axis_preload, fifo_read, axis_clear, busy, done, err_tlast;
    logic [31:0]   stall_cycles;

    preload_fifo_ctrl_if bus();

    preload_fifo_ctrl #(.AXIS_PRELOAD_FIFO_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .input_channel_size (size),
        .row_count          (rows_in),
        .ctrl_bus           (bus),
        .fifo_cnt           (fifo_cnt),
        .fifo_full          (fifo_full),
        .load_axis_preload  (load_axis_preload),
        .fifo_read          (fifo_read),
        .axis_clear         (axis_clear),
        .busy               (busy),
        .done               (done),
        .err_tlast          (err_tlast),
        .stall_cycles       (stall_cycles)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Job-level reference model: 0 idle, 1 clear, 2 load, 3 drain, 4 done.
    int     m_phase = 0;
    int     m_wpr = 1, m_rows = 0, m_total = 0, m_acc = 0, m_pops = 0;
    bit     m_err = 0;
    longint m_stall = 0;
    bit     force_full = 0;
    int     n_load = 0, n_read = 0, n_done = 0, n_clear = 0;

    typedef struct {
        int sz; int rc; int hold; int bad;
        int exp_words; int exp_pops; int exp_err;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare one cycle against the model, then advance both across the clock edge.
    task automatic step();
        int occ;
        bit e_mv, e_rd, e_rdy, e_ld, fin;
        occ = (m_acc + m_wpr - 1) / m_wpr - m_pops;
        fifo_full = (occ >= int'(DEPTH)) || force_full;
        fifo_cnt  = CW'(occ);
        #2;
        e_mv  = ((m_phase == 2) || (m_phase == 3)) && (m_acc / m_wpr > m_pops);
        e_rd  = e_mv && bus.mac_ready;
        e_rdy = (m_phase == 2) && (m_acc < m_total) && (!fifo_full || e_rd);
        e_ld  = bus.s_axis_tvalid && e_rdy;
        chk("busy", busy, m_phase != 0);
        chk("axis_clear", axis_clear, m_phase == 1);
        chk("done", done, m_phase == 4);
        chk("mac_valid", bus.mac_valid, e_mv);
        chk("fifo_read", fifo_read, e_rd);
        chk("tready", bus.s_axis_tready, e_rdy);
        chk("load", load_axis_preload, e_ld);
        chk("err_tlast", err_tlast, m_err);
        chk("stall_cycles", stall_cycles, m_stall);
        n_load  += int'(load_axis_preload);
        n_read  += int'(fifo_read);
        n_done  += int'(done);
        n_clear += int'(axis_clear);
        fin = e_ld && (m_acc + 1 == m_total);
        if (e_ld) begin
            if (bus.s_axis_tlast != fin) m_err = 1;
            m_acc++;
        end
        if (e_rd) m_pops++;
`ifdef PRELOAD_CTRL_PERF_EN
        if ((m_phase == 2) && bus.s_axis_tvalid && !e_rdy && (m_stall < 64'hFFFF_FFFF)) m_stall++;
`endif
        case (m_phase)
            0: if (start) begin
                m_phase = 1;
                m_wpr   = int'(size) / 6 + 1;
                m_rows  = int'(rows_in);
                m_total = m_wpr * m_rows;
                m_acc = 0; m_pops = 0; m_err = 0; m_stall = 0;
            end
            1: m_phase = (m_rows == 0) ? 4 : 2;
            2: if (fin) m_phase = 3;
            3: if (m_pops == m_rows) m_phase = 4;
            default: m_phase = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int sz, input int rc, input int hold, input int bad, input bit rnd);
        int cyc;
        bit started;
        cyc = 0; started = 0;
        n_load = 0; n_read = 0; n_done = 0; n_clear = 0;
        size = 12'(sz);
        rows_in = 16'(rc);
        while (!(started && m_phase == 0) && cyc < 3000) begin
            start = !started ? 1'b1 : (rnd && ($urandom_range(7) == 0));
            bus.s_axis_tvalid = rnd ? ($urandom_range(3) != 0) : 1'b1;
            bus.mac_ready = (cyc >= hold) && (rnd ? ($urandom_range(2) != 0) : 1'b1);
            bus.s_axis_tlast = (bad != 0) ? (m_acc + 1 == bad) : (m_acc + 1 == m_total);
            step();
            started = 1;
            cyc++;
        end
        if (cyc >= 3000) begin
            checks++; errors++;
            $display("FAIL job_timeout: got %0d cycles, required fewer than 3000", cyc);
        end
        start = 0;
        bus.s_axis_tvalid = 0;
        bus.s_axis_tlast = 0;
    endtask

    initial begin
        vec_t vecs[7];
        int cyc;
        vecs[0] = '{11, 3,  0,  0,  6, 3, 0};
        vecs[1] = '{11, 2,  0,  2,  4, 2, 1};
        vecs[2] = '{11, 0,  0,  0,  0, 0, 0};
        vecs[3] = '{ 5, 6, 20,  0,  6, 6, 0};
        vecs[4] = '{30, 2,  0,  0, 12, 2, 0};
        vecs[5] = '{ 0, 1,  0, -1,  1, 1, 1};
        vecs[6] = '{12, 4,  5,  0, 12, 4, 0};

        bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0; bus.mac_ready = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_tready", bus.s_axis_tready, 0);
        chk("rst_done", done, 0);
        chk("rst_clear", axis_clear, 0);
        chk("rst_stall", stall_cycles, 0);
        @(posedge clk); #1;
        rst_n = 1;

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].sz, vecs[i].rc, vecs[i].hold, vecs[i].bad, 1'b0);
            chk($sformatf("vec%0d_words", i), n_load, vecs[i].exp_words);
            chk($sformatf("vec%0d_pops", i), n_read, vecs[i].exp_pops);
            chk($sformatf("vec%0d_done", i), n_done, 1);
            chk($sformatf("vec%0d_clear", i), n_clear, 1);
            chk($sformatf("vec%0d_err", i), err_tlast, vecs[i].exp_err);
        end

        // Reset in LOAD after three accepted words.
        size = 12'd11; rows_in = 16'd3;
        bus.s_axis_tvalid = 1; bus.mac_ready = 0; bus.s_axis_tlast = 0;
        start = 1; step(); start = 0;
        cyc = 0;
        while (m_acc < 3 && cyc < 50) begin step(); cyc++; end
        chk("pre_rst_words", m_acc, 3);
        rst_n = 0;
        #1;
        chk("mid_rst_tready", bus.s_axis_tready, 0);
        chk("mid_rst_load", load_axis_preload, 0);
        chk("mid_rst_read", fifo_read, 0);
        chk("mid_rst_mac_valid", bus.mac_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_clear", axis_clear, 0);
        chk("mid_rst_done", done, 0);
        m_phase = 0; m_acc = 0; m_pops = 0; m_err = 0; m_stall = 0;
        @(posedge clk); #1;
        rst_n = 1;
        bus.s_axis_tvalid = 0;
        run_job(11, 3, 0, 0, 1'b0);
        chk("post_rst_words", n_load, 6);
        chk("post_rst_pops", n_read, 3);
        chk("post_rst_clear", n_clear, 1);

        // Input stalled by a held-full FIFO for ten LOAD cycles.
        size = 12'd5; rows_in = 16'd3;
        bus.s_axis_tvalid = 1; bus.mac_ready = 0; bus.s_axis_tlast = 0;
        start = 1; step(); start = 0;
        step();
        force_full = 1;
        for (int i = 0; i < 10; i++) step();
        force_full = 0;
        chk("stall_count", stall_cycles, STALL_EXP);
        bus.mac_ready = 1;
        cyc = 0;
        while (m_phase != 0 && cyc < 100) begin
            bus.s_axis_tlast = (m_acc + 1 == m_total);
            step(); cyc++;
        end
        chk("stall_job_end", m_phase, 0);
        bus.s_axis_tvalid = 0;

        // Random jobs with random backpressure, stray starts and occasional bad tlast.
        for (int j = 0; j < 12; j++) begin
            int sz, rc, bad, tot;
            sz  = int'($urandom_range(40));
            rc  = int'($urandom_range(7));
            tot = (sz / 6 + 1) * rc;
            bad = ($urandom_range(3) == 0 && tot > 0) ? int'($urandom_range(1, tot)) : 0;
            run_job(sz, rc, int'($urandom_range(10)), bad, 1'b1);
            chk($sformatf("rand%0d_words", j), n_load, tot);
            chk($sformatf("rand%0d_pops", j), n_read, rc);
            chk($sformatf("rand%0d_done", j), n_done, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/preload_fifo_ctrl.md
PRELOAD_FIFO_CTRL -- requirements
Module: preload_fifo_ctrl

Interface
REQ-001 Parameter AXIS_PRELOAD_FIFO_DEPTH, default 4, SHALL be the entry count of the controlled preload FIFO.
REQ-002 Parameter CNT_W, default clogb2(AXIS_PRELOAD_FIFO_DEPTH-1)+1, SHALL be the FIFO occupancy width.
REQ-003 Ports SHALL be:
 clk  in  1  clock, all logic on rising edge
 rst_n  in  1  reset, asynchronous, active-low
 start  in  1  job start pulse
 input_channel_size  in  12  channels per row
 row_count  in  16  rows (FIFO entries) per job
 s_axis_tvalid  in  1  AXIS word valid
 s_axis_tlast  in  1  AXIS last word of job
 s_axis_tready  out  1  AXIS ready
 fifo_cnt  in  CNT_W  FIFO occupancy
 fifo_full  in  1  FIFO full
 load_axis_preload  out  1  FIFO write strobe
 fifo_read  out  1  FIFO pop strobe
 axis_clear  out  1  FIFO pointer clear
 mac_valid  out  1  complete row at FIFO head
 mac_ready  in  1  MAC array accepts row
 busy  out  1  job in progress
 done  out  1  one-cycle job-complete pulse
 err_tlast  out  1  sticky tlast mismatch
 stall_cycles  out  32  input-stall counter

Function
REQ-004 words_per_row SHALL equal input_channel_size/6+1 (integer division), latched with row_count at start.
REQ-005 FSM states SHALL be IDLE, CLEAR, LOAD, DRAIN, DONE.
REQ-006 IDLE->CLEAR on start; start outside IDLE SHALL be ignored.
REQ-007 CLEAR SHALL last one cycle with axis_clear=1; next state is DONE if latched row_count==0, else LOAD.
REQ-008 s_axis_tready SHALL be 1 only in LOAD, while words accepted < words_per_row*row_count, and (!fifo_full or fifo_read).
REQ-009 load_axis_preload SHALL equal s_axis_tvalid & s_axis_tready, combinationally.
REQ-010 A word counter (0..words_per_row-1) SHALL wrap on each row's last word, incrementing rows_written (16 bit).
REQ-011 mac_valid SHALL be 1 in LOAD/DRAIN when rows_written > rows_read; fifo_cnt alone SHALL NOT drive mac_valid (FIFO counts partially written rows).
REQ-012 fifo_read SHALL equal mac_valid & mac_ready; each pop increments rows_read.
REQ-013 A row completing write and a pop in the same cycle SHALL leave (rows_written-rows_read) unchanged.
REQ-014 LOAD->DRAIN when the final word of the job is accepted; DRAIN->DONE when rows_read reaches row_count (including the same-cycle final pop).
REQ-015 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 err_tlast SHALL set when an accepted word has tlast=1 but is not the final job word, or is the final word with tlast=0; it clears only on start accepted in IDLE; the job continues regardless.

Reset
REQ-018 rst_n low SHALL force IDLE, clear all counters and err_tlast, and drive s_axis_tready, load_axis_preload, fifo_read, axis_clear, mac_valid, busy, done to 0, and stall_cycles to 0.
REQ-019 Reset mid-job SHALL abandon the job; the next start's CLEAR resets FIFO pointers.

Configuration
REQ-020 With PRELOAD_CTRL_PERF_EN defined, stall_cycles SHALL count cycles in LOAD with s_axis_tvalid=1 and s_axis_tready=0, saturating at 2^32-1, cleared at start.
REQ-021 Without PRELOAD_CTRL_PERF_EN, stall_cycles SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-022 FSM state encoding and the channels-per-word constant (6) SHALL live in shared package preload_pkg.
REQ-023 Row/word counting SHALL be a sub-module preload_row_counter (word counter, rows_written, rows_read, occupancy compare).

Verification
REQ-024 size=11, row_count=3, mac_ready=1, tvalid=1 -> 6 words accepted, 3 pops, tlast on word 6, done one cycle, err_tlast=0.
REQ-025 size=5, row_count=6, depth 4, mac_ready=0 -> tready drops with fifo_full after 4 rows; mac_ready=1 resumes; 6 pops total.
REQ-026 size=11, row_count=2, tlast on word 2 -> err_tlast=1, job completes with 4 words, done pulses.
REQ-027 row_count=0, start -> axis_clear one cycle, done next cycle, no tready.
REQ-028 Reset asserted in LOAD after 3 words -> outputs 0 immediately; new start runs complete job with axis_clear.
REQ-029 PRELOAD_CTRL_PERF_EN defined, tvalid=1 with fifo_full held 10 cycles in LOAD -> stall_cycles=10.
